// File: rtl/multi_channel_clock_divider.sv
// Multi-channel programmable clock/tick divider.
// Each channel divides clk by its own divisor D. It produces a divided clock
// that is high for ceil(D/2) cycles and a one-cycle tick at each period start.
// A new divisor waits in a pending register and takes effect only at a period
// boundary. sync_restart restarts all enabled channels in phase.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           per-channel run enable
//   wr_en        divisor write strobe
//   wr_ch        channel index for the write (out-of-range indices are ignored)
//   wr_div       divisor value to write
//   sync_restart one-cycle strobe that restarts every enabled channel
//   clk_out      registered divided clock per channel
//   tick         registered one-cycle period-start pulse per channel
//   pend         registered flag: a written divisor is waiting to be applied
module multi_channel_clock_divider #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 4,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0]  cnt_q  [NUM_CH];
    logic [DIV_W-1:0]  act_q  [NUM_CH];
    logic [DIV_W-1:0]  pdiv_q [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] prev_en_q;
    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] tick_q;

    logic [DIV_W-1:0]  cnt_d  [NUM_CH];
    logic [DIV_W-1:0]  act_d  [NUM_CH];
    logic [DIV_W-1:0]  pdiv_d [NUM_CH];
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] tick_d;

    logic [DIV_W-1:0]  d_sel   [NUM_CH];
    logic [DIV_W-1:0]  cnt_inc [NUM_CH];
    logic [DIV_W:0]    hi      [NUM_CH];
    logic              wr_hit;

    assign wr_hit = wr_en && (32'(wr_ch) < NUM_CH);

    // Next-state logic per channel
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // Divisor that governs a period starting at this edge
            d_sel[i]   = pend_q[i] ? pdiv_q[i] : act_q[i];
            cnt_inc[i] = cnt_q[i] + DIV_W'(1);
            hi[i]      = ({1'b0, act_q[i]} + (DIV_W + 1)'(1)) >> 1;

            cnt_d[i]  = cnt_q[i];
            act_d[i]  = act_q[i];
            pdiv_d[i] = pdiv_q[i];
            pend_d[i] = pend_q[i];
            clk_d[i]  = 1'b0;
            tick_d[i] = 1'b0;

            if (!en[i]) begin
                // Idle channel: park at phase 0, pending divisor lands at once
                cnt_d[i]  = '0;
                act_d[i]  = d_sel[i];
                pend_d[i] = 1'b0;
            end else if (!prev_en_q[i] || sync_restart || (act_q[i] == '0) ||
                         (cnt_q[i] >= act_q[i] - DIV_W'(1))) begin
                // Period boundary: enable edge, restart, stopped (D=0) or wrap.
                // The applied divisor already shapes this edge's outputs.
                cnt_d[i]  = '0;
                act_d[i]  = d_sel[i];
                pend_d[i] = 1'b0;
                tick_d[i] = (d_sel[i] != '0);
                clk_d[i]  = (d_sel[i] != '0);
            end else begin
                cnt_d[i] = cnt_inc[i];
                clk_d[i] = ({1'b0, cnt_inc[i]} < hi[i]);
            end

            // A write lands after any application, so it stays pending
            if (wr_hit && (wr_ch == CH_W'(i))) begin
                pdiv_d[i] = wr_div;
                pend_d[i] = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                act_q[i]  <= DEF_DIV;
                pdiv_q[i] <= DEF_DIV;
            end
            pend_q    <= '0;
            prev_en_q <= '0;
            clk_q     <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                act_q[i]  <= act_d[i];
                pdiv_q[i] <= pdiv_d[i];
            end
            pend_q    <= pend_d;
            prev_en_q <= en;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

endmodule
